// File: rtl/bg_fetch_arbiter.sv
// Round-robin arbiter sharing one background/scoreboard ROM read port among three renderers.
// Fixed-latency reads return tagged to the issuing requester; flush quiesces the port before reloads.
module bg_fetch_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        gnt,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic [2:0]        rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    output logic              flush_done
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_FLUSHED
    } state_t;

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [2:0]        r_gnt;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_flush_done;
    logic [2:0]        r_tag [RD_LAT];
    logic [CNT_W-1:0]  r_inflight;

    logic [2:0]        w_eligible;
    logic              w_any;
    logic [1:0]        w_first;
    logic [1:0]        w_second;
    logic [1:0]        w_third;
    logic [1:0]        w_winner;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_issue;
    logic              w_ret;
    logic [CNT_W-1:0]  w_inflight_nxt;

    // A requester granted this cycle is masked so it cannot win again before it can drop req.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_eligible = req & ~r_gnt;
        w_any      = |w_eligible;
        w_first    = 2'd0;
        w_second   = 2'd1;
        w_third    = 2'd2;
        case (r_ptr)
            2'd0:    begin w_first = 2'd1; w_second = 2'd2; w_third = 2'd0; end
            2'd1:    begin w_first = 2'd2; w_second = 2'd0; w_third = 2'd1; end
            default: begin w_first = 2'd0; w_second = 2'd1; w_third = 2'd2; end
        endcase
        if (w_eligible[w_first])
            w_winner = w_first;
        else if (w_eligible[w_second])
            w_winner = w_second;
        else
            w_winner = w_third;
        case (w_winner)
            2'd0:    w_win_addr = addr0;
            2'd1:    w_win_addr = addr1;
            default: w_win_addr = addr2;
        endcase
        w_issue        = |r_gnt;
        w_ret          = |r_tag[RD_LAT-1];
        w_inflight_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(w_ret);
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (Reset) begin
            r_state      <= ST_RUN;
            r_ptr        <= 2'd2;
            r_gnt        <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_flush_done <= 1'b0;
            r_inflight   <= '0;
            // NOTE: the tag pipe is reset explicitly so reads in flight at reset never surface.
            for (int k = 0; k < RD_LAT; k++)
                r_tag[k] <= '0;
        end else begin
            r_tag[0] <= r_gnt;
            for (int k = 1; k < RD_LAT; k++)
                r_tag[k] <= r_tag[k-1];
            r_inflight <= w_inflight_nxt;
            r_gnt      <= '0;
            r_mem_rd   <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_DRAIN;
                    end else if (w_any) begin
                        r_gnt      <= 3'b001 << w_winner;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_win_addr;
                        r_ptr      <= w_winner;
                    end
                end
                ST_DRAIN: begin
                    // Counter includes the last grant issued before the flush was seen.
                    if (w_inflight_nxt == '0) begin
                        r_state      <= ST_FLUSHED;
                        r_flush_done <= 1'b1;
                    end
                end
                ST_FLUSHED: begin
                    if (!flush) begin
                        r_state      <= ST_RUN;
                        r_flush_done <= 1'b0;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign rd_valid   = r_tag[RD_LAT-1];
    assign rd_data    = mem_q;
    assign flush_done = r_flush_done;

endmodule

// File: tb/tb_bg_fetch_arbiter.sv
// Scoreboard bench for bg_fetch_arbiter: three instances (RD_LAT 1, 2, 4) share directed stimulus;
// expected grants, returns and flush_done edges are queued with their cycle and popped by a monitor.
module tb_bg_fetch_arbiter;

    typedef struct {
        int          cyc;
        logic [2:0]  tag;
        logic [18:0] val;
    } ev_t;

    logic        Clk;
    logic        Reset;
    logic [2:0]  req;
    logic [18:0] addr0, addr1, addr2;
    logic        flush;

    logic [2:0]  gnt_w      [3];
    logic        mem_rd_w   [3];
    logic [18:0] mem_addr_w [3];
    logic [7:0]  mem_q_w    [3];
    logic [2:0]  rd_valid_w [3];
    logic [7:0]  rd_data_w  [3];
    logic        fd_w       [3];
    logic        fd_prev    [3];

    ev_t q_gnt [3][$];
    ev_t q_ret [3][$];
    ev_t q_fd  [3][$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] rom_fn(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT_G = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [7:0] rom_pipe [LAT_G];

        bg_fetch_arbiter #(.ADDR_W(19), .DATA_W(8), .RD_LAT(LAT_G)) u_dut (
            .Clk        (Clk),
            .Reset      (Reset),
            .req        (req),
            .addr0      (addr0),
            .addr1      (addr1),
            .addr2      (addr2),
            .gnt        (gnt_w[g]),
            .mem_rd     (mem_rd_w[g]),
            .mem_addr   (mem_addr_w[g]),
            .mem_q      (mem_q_w[g]),
            .rd_valid   (rd_valid_w[g]),
            .rd_data    (rd_data_w[g]),
            .flush      (flush),
            .flush_done (fd_w[g])
        );

        // ROM model: never reset, so stale data keeps arriving after a DUT reset.
        always @(posedge Clk) begin
            rom_pipe[0] <= mem_rd_w[g] ? rom_fn(mem_addr_w[g]) : 8'hEE;
            for (int k = 1; k < LAT_G; k++)
                rom_pipe[k] <= rom_pipe[k-1];
        end
        assign mem_q_w[g] = rom_pipe[LAT_G-1];
    end

    task automatic check(input bit ok, input string name, input string got, input string want);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    // Monitor: pops an expectation whenever a DUT presents a grant, a return or a flush_done edge.
    initial begin
        for (int i = 0; i < 3; i++) fd_prev[i] = 1'b0;
    end

    always @(negedge Clk) begin
        ev_t e;
        for (int i = 0; i < 3; i++) begin
            if (gnt_w[i] != 3'b000 || mem_rd_w[i] == 1'b1) begin
                if (q_gnt[i].size() == 0)
                    check(1'b0, $sformatf("grant_unexpected_lat%0d", lat(i)),
                          $sformatf("gnt=%b mem_rd=%b at cyc %0d", gnt_w[i], mem_rd_w[i], cyc), "no grant");
                else begin
                    e = q_gnt[i].pop_front();
                    check(cyc == e.cyc && gnt_w[i] == e.tag && mem_rd_w[i] == 1'b1 && mem_addr_w[i] == e.val,
                          $sformatf("grant_lat%0d", lat(i)),
                          $sformatf("cyc %0d gnt=%b rd=%b addr=%h", cyc, gnt_w[i], mem_rd_w[i], mem_addr_w[i]),
                          $sformatf("cyc %0d gnt=%b rd=1 addr=%h", e.cyc, e.tag, e.val));
                end
            end
            if (rd_valid_w[i] != 3'b000) begin
                if (q_ret[i].size() == 0)
                    check(1'b0, $sformatf("return_unexpected_lat%0d", lat(i)),
                          $sformatf("rd_valid=%b at cyc %0d", rd_valid_w[i], cyc), "no return");
                else begin
                    e = q_ret[i].pop_front();
                    check(cyc == e.cyc && rd_valid_w[i] == e.tag && rd_data_w[i] == e.val[7:0],
                          $sformatf("return_lat%0d", lat(i)),
                          $sformatf("cyc %0d valid=%b data=%h", cyc, rd_valid_w[i], rd_data_w[i]),
                          $sformatf("cyc %0d valid=%b data=%h", e.cyc, e.tag, e.val[7:0]));
                end
            end
            if (fd_w[i] !== fd_prev[i]) begin
                if (q_fd[i].size() == 0)
                    check(1'b0, $sformatf("flush_done_unexpected_lat%0d", lat(i)),
                          $sformatf("flush_done=%b at cyc %0d", fd_w[i], cyc), "no change");
                else begin
                    e = q_fd[i].pop_front();
                    check(cyc == e.cyc && fd_w[i] == e.tag[0], $sformatf("flush_done_lat%0d", lat(i)),
                          $sformatf("cyc %0d flush_done=%b", cyc, fd_w[i]),
                          $sformatf("cyc %0d flush_done=%b", e.cyc, e.tag[0]));
                end
                fd_prev[i] = fd_w[i];
            end
        end
    end

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    // Grant expected at cycle c; its return is expected only if it lands at or before ret_limit.
    task automatic exp_gnt(input int c, input logic [2:0] tag, input logic [18:0] a, input int ret_limit);
        ev_t e;
        for (int i = 0; i < 3; i++) begin
            e.cyc = c; e.tag = tag; e.val = a;
            q_gnt[i].push_back(e);
            if (c + lat(i) <= ret_limit) begin
                e.cyc = c + lat(i); e.val = {11'd0, rom_fn(a)};
                q_ret[i].push_back(e);
            end
        end
    endtask

    task automatic exp_fd(input int c, input bit add_lat, input logic v);
        ev_t e;
        for (int i = 0; i < 3; i++) begin
            e.cyc = add_lat ? c + lat(i) : c;
            e.tag = {2'b00, v};
            e.val = '0;
            q_fd[i].push_back(e);
        end
    endtask

    task automatic settle(input string name);
        repeat (12) next();
        for (int i = 0; i < 3; i++)
            check(q_gnt[i].size() == 0 && q_ret[i].size() == 0 && q_fd[i].size() == 0,
                  $sformatf("%s_pending_lat%0d", name, lat(i)),
                  $sformatf("%0d/%0d/%0d events left", q_gnt[i].size(), q_ret[i].size(), q_fd[i].size()),
                  "0/0/0");
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req   = 3'b000;
        flush = 1'b0;
        next();
        next();
        Reset = 1'b0;
        next();
    endtask

    localparam int NO_LIMIT = 32'h3FFF_FFFF;

    initial begin
        int c;
        int f;
        Reset = 1'b1;
        req   = 3'b000;
        flush = 1'b0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        do_reset();

        // Reset state
        @(negedge Clk);
        for (int i = 0; i < 3; i++)
            check(gnt_w[i] == 3'b000 && mem_rd_w[i] == 1'b0 && mem_addr_w[i] == 19'd0 &&
                  rd_valid_w[i] == 3'b000 && fd_w[i] == 1'b0,
                  $sformatf("reset_state_lat%0d", lat(i)),
                  $sformatf("gnt=%b rd=%b addr=%h valid=%b fd=%b", gnt_w[i], mem_rd_w[i],
                            mem_addr_w[i], rd_valid_w[i], fd_w[i]),
                  "all zero");

        // One-shot request from requester 0
        next();
        c = cyc;
        addr0 = 19'h000A0;
        req   = 3'b001;
        exp_gnt(c + 1, 3'b001, 19'h000A0, NO_LIMIT);
        next();
        req = 3'b000;
        settle("one_shot");

        // All three requesting: 0,1,2 rotation, out-of-range address passes through
        do_reset();
        addr0 = 19'h00123; addr1 = 19'h24C10; addr2 = 19'h7FFFF;
        c = cyc;
        req = 3'b111;
        for (int k = 0; k < 9; k++)
            case (k % 3)
                0:       exp_gnt(c + 1 + k, 3'b001, 19'h00123, NO_LIMIT);
                1:       exp_gnt(c + 1 + k, 3'b010, 19'h24C10, NO_LIMIT);
                default: exp_gnt(c + 1 + k, 3'b100, 19'h7FFFF, NO_LIMIT);
            endcase
        repeat (9) next();
        req = 3'b000;
        settle("round_robin");

        // Single requester held: grant every other cycle
        do_reset();
        addr1 = 19'h1F0F0;
        c = cyc;
        req = 3'b010;
        exp_gnt(c + 1, 3'b010, 19'h1F0F0, NO_LIMIT);
        exp_gnt(c + 3, 3'b010, 19'h1F0F0, NO_LIMIT);
        exp_gnt(c + 5, 3'b010, 19'h1F0F0, NO_LIMIT);
        repeat (6) next();
        req = 3'b000;
        settle("single_held");

        // Flush while all request, then resume from ptr+1
        do_reset();
        addr0 = 19'h00040; addr1 = 19'h12345; addr2 = 19'h4AB00;
        c = cyc;
        f = c + 14;
        req = 3'b111;
        exp_gnt(c + 1, 3'b001, 19'h00040, NO_LIMIT);
        exp_gnt(c + 2, 3'b010, 19'h12345, NO_LIMIT);
        exp_gnt(c + 3, 3'b100, 19'h4AB00, NO_LIMIT);
        exp_gnt(c + 4, 3'b001, 19'h00040, NO_LIMIT);
        exp_fd(c + 5, 1'b1, 1'b1);
        exp_fd(f + 1, 1'b0, 1'b0);
        exp_gnt(f + 2, 3'b010, 19'h12345, NO_LIMIT);
        exp_gnt(f + 3, 3'b100, 19'h4AB00, NO_LIMIT);
        repeat (4) next();
        flush = 1'b1;
        repeat (10) next();
        flush = 1'b0;
        repeat (3) next();
        req = 3'b000;
        settle("flush_run");

        // Flush pulse dropped during DRAIN still passes through FLUSHED
        do_reset();
        addr0 = 19'h0BEEF;
        c = cyc;
        req = 3'b001;
        exp_gnt(c + 1, 3'b001, 19'h0BEEF, NO_LIMIT);
        exp_fd(c + 2, 1'b1, 1'b1);
        exp_fd(c + 3, 1'b1, 1'b0);
        next();
        req   = 3'b000;
        flush = 1'b1;
        next();
        flush = 1'b0;
        settle("flush_pulse");

        // Reset one cycle after gnt=100 discards in-flight reads
        do_reset();
        addr0 = 19'h00011; addr1 = 19'h00222; addr2 = 19'h03330;
        c = cyc;
        req = 3'b111;
        exp_gnt(c + 1, 3'b001, 19'h00011, c + 4);
        exp_gnt(c + 2, 3'b010, 19'h00222, c + 4);
        exp_gnt(c + 3, 3'b100, 19'h03330, c + 4);
        exp_gnt(c + 4, 3'b001, 19'h00011, c + 4);
        exp_gnt(c + 6, 3'b001, 19'h00011, NO_LIMIT);
        exp_gnt(c + 7, 3'b010, 19'h00222, NO_LIMIT);
        repeat (4) next();
        Reset = 1'b1;
        next();
        Reset = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 3; i++)
            check(mem_rd_w[i] == 1'b0 && gnt_w[i] == 3'b000 && rd_valid_w[i] == 3'b000,
                  $sformatf("reset_mid_read_lat%0d", lat(i)),
                  $sformatf("rd=%b gnt=%b valid=%b", mem_rd_w[i], gnt_w[i], rd_valid_w[i]),
                  "rd=0 gnt=000 valid=000");
        next();
        next();
        req = 3'b000;
        settle("reset_mid_read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1);
    end

endmodule
